// File: rtl/score_display_pkg.sv
// Shared geometry constants, pipeline stage record and BCD helper for the Pong score display.
package score_display_pkg;

    localparam int VERTICAL_SCORE_OFFSET = 16;
    localparam int GLYPH_W               = 4;
    localparam int GLYPH_H               = 7;
    localparam int DIGIT_PITCH           = 8;
    localparam int CRD_W                 = 12;

    typedef struct packed {
        logic       in_window;
        logic [2:0] col;
        logic [2:0] row;
        logic [3:0] digit;
        logic       blank;
        logic       blink_on;
    } s1_t;

    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_display_if.sv
// Pixel/score bus between the video timing side and one player's score display.
interface score_display_if #(
    parameter int NUM_DIGITS = 2
) ();
    logic [11:0]               x;
    logic [11:0]               y;
    logic [11:0]               horizontal_offset;
    logic                      point;
    logic                      new_game;
    logic                      frame_tick;
    logic                      out;
    logic                      win;
    logic [4*NUM_DIGITS-1:0]   score_bcd;

    modport master (
        output x, y, horizontal_offset, point, new_game, frame_tick,
        input  out, win, score_bcd
    );

    modport slave (
        input  x, y, horizontal_offset, point, new_game, frame_tick,
        output out, win, score_bcd
    );
endinterface

// File: rtl/score_display_glyph_rom.sv
// 4x7 block-font digit ROM; each glyph row is one nibble, bit 3 is the leftmost column.
module score_glyph_rom (
    input  logic [3:0] digit,
    input  logic [2:0] row,
    output logic [3:0] bits
);

    logic [27:0] glyph;

    // Row 0 sits in the most significant nibble.
    always_comb begin
        glyph = '0;
        case (digit)
            4'd0: glyph = 28'hF99999F;
            4'd1: glyph = 28'h2622227;
            4'd2: glyph = 28'hF11F88F;
            4'd3: glyph = 28'hF11F11F;
            4'd4: glyph = 28'h999F111;
            4'd5: glyph = 28'hF88F11F;
            4'd6: glyph = 28'hF88F99F;
            4'd7: glyph = 28'hF112444;
            4'd8: glyph = 28'hF99F99F;
            4'd9: glyph = 28'hF99F11F;
            default: glyph = '0;
        endcase
    end

    always_comb begin
        bits = '0;
        if (row != 3'd7) begin
            bits = 4'(glyph >> (4 * (6 - int'(row))));
        end
    end

endmodule

// File: rtl/score_display.sv
// Per-player BCD score counter with win flag, win blink and a 2-stage block-font pixel renderer.
module score_display
    import score_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int SEG_SIZE     = 4,
    parameter int WIN_SCORE    = 11,
    parameter int BLINK_FRAMES = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    score_display_if.slave bus
);

    localparam int SW    = 4 * NUM_DIGITS;
    localparam int SHIFT = $clog2(SEG_SIZE);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [15:0]      WIN_BCD16  = to_bcd(WIN_SCORE);
    localparam logic [15:0]      NINES_BCD16 = to_bcd((10 ** NUM_DIGITS) - 1);
    localparam logic [SW-1:0]    WIN_BCD    = WIN_BCD16[SW-1:0];
    localparam logic [SW-1:0]    ALL_NINES  = NINES_BCD16[SW-1:0];
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    localparam logic [CRD_W-1:0] WIN_W_PIX = CRD_W'(NUM_DIGITS * DIGIT_PITCH * SEG_SIZE);
    localparam logic [CRD_W-1:0] WIN_H_PIX = CRD_W'(GLYPH_H * SEG_SIZE);
    localparam logic [CRD_W-1:0] VSO       = CRD_W'(VERTICAL_SCORE_OFFSET);

    logic [SW-1:0]    score_q, score_d;
    logic             win_q, win_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_on_q, blink_on_d;
    s1_t              s1_q, s1_d;
    logic             out_q, out_d;

    logic [SW-1:0]    score_inc;
    logic             carry;
    logic [CRD_W-1:0] rx, ry;
    logic             in_win;
    logic [1:0]       slot;
    int               pos;
    logic [3:0]       rom_bits;
    logic             glyph_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            score_q     <= '0;
            win_q       <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            s1_q        <= '0;
            out_q       <= 1'b0;
        end else begin
            score_q     <= score_d;
            win_q       <= win_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            s1_q        <= s1_d;
            out_q       <= out_d;
        end
    end

    // Ripple BCD increment from digit 0 upward.
    always_comb begin
        score_inc = score_q;
        carry     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (score_inc[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_inc[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        score_d     = score_q;
        win_d       = win_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (bus.new_game) begin
            score_d     = '0;
            win_d       = 1'b0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else begin
            if (bus.point && !win_q && (score_q != ALL_NINES)) begin
                score_d = score_inc;
            end
            if (score_q == WIN_BCD) begin
                win_d = 1'b1;
            end
            if (!win_q) begin
                blink_cnt_d = '0;
                blink_on_d  = 1'b1;
            end else if (bus.frame_tick) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    blink_on_d  = ~blink_on_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign rx     = bus.x - bus.horizontal_offset;
    assign ry     = bus.y - VSO;
    assign in_win = (bus.x >= bus.horizontal_offset) && (bus.y >= VSO) &&
                    (rx < WIN_W_PIX) && (ry < WIN_H_PIX);
    assign slot   = 2'(rx >> (SHIFT + 3));

    // Slot 0 is the leftmost, i.e. most significant, digit.
    always_comb begin
        s1_d           = '0;
        pos            = 0;
        s1_d.in_window = in_win;
        s1_d.col       = 3'(rx >> SHIFT);
        s1_d.row       = 3'(ry >> SHIFT);
        s1_d.blink_on  = blink_on_q;
        if (int'(slot) < NUM_DIGITS) begin
            pos        = NUM_DIGITS - 1 - int'(slot);
            s1_d.digit = score_q[4*pos +: 4];
            s1_d.blank = (pos != 0) && ((score_q >> (4 * pos)) == '0);
        end
    end

    score_glyph_rom u_rom (
        .digit (s1_q.digit),
        .row   (s1_q.row),
        .bits  (rom_bits)
    );

    assign glyph_bit = ~s1_q.col[2] & rom_bits[2'd3 - s1_q.col[1:0]];

    always_comb begin
        out_d = s1_q.in_window & glyph_bit & ~s1_q.blank & s1_q.blink_on;
    end

    assign bus.out       = out_q;
    assign bus.win       = win_q;
    assign bus.score_bcd = score_q;

endmodule

// File: tb/tb_score_display.sv
// Randomized bench for score_display against a decimal/pixel reference model.
module tb_score_display;
    import score_display_pkg::*;

    localparam int ND  = 2;
    localparam int SEG = 4;
    localparam int WIN = 11;
    localparam int BF  = 2;
    localparam int VSO = VERTICAL_SCORE_OFFSET;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    score_display_if #(.NUM_DIGITS(ND)) bus  ();
    score_display_if #(.NUM_DIGITS(1))  bus1 ();

    score_display #(.NUM_DIGITS(ND), .SEG_SIZE(SEG), .WIN_SCORE(WIN), .BLINK_FRAMES(BF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    score_display #(.NUM_DIGITS(1), .SEG_SIZE(1), .WIN_SCORE(9), .BLINK_FRAMES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int m_score  = 0;
    int m_bc     = 0;
    bit m_win    = 1'b0;
    bit m_bon    = 1'b1;
    bit m_s1     = 1'b0;
    bit m_out    = 1'b0;
    int m1_score = 0;
    bit m1_win   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit glyph_lit(input int d, input int r, input int c);
        string art;
        case (d)
            0: art = "#### #..# #..# #..# #..# #..# ####";
            1: art = "..#. .##. ..#. ..#. ..#. ..#. .###";
            2: art = "#### ...# ...# #### #... #... ####";
            3: art = "#### ...# ...# #### ...# ...# ####";
            4: art = "#..# #..# #..# #### ...# ...# ...#";
            5: art = "#### #... #... #### ...# ...# ####";
            6: art = "#### #... #... #### #..# #..# ####";
            7: art = "#### ...# ...# ..#. .#.. .#.. .#..";
            8: art = "#### #..# #..# #### #..# #..# ####";
            default: art = "#### #..# #..# #### ...# ...# ####";
        endcase
        return art[r*5 + c] == "#";
    endfunction

    function automatic bit exp_pix(input int x, input int y, input int off, input int score, input bit bon);
        int rx, ry, cx, cy, slot, col, pos, p10, digit;
        if (x < off || y < VSO) return 1'b0;
        rx = x - off;
        ry = y - VSO;
        if (rx >= ND * 8 * SEG || ry >= 7 * SEG) return 1'b0;
        cx   = rx / SEG;
        cy   = ry / SEG;
        slot = cx / 8;
        col  = cx % 8;
        if (col >= 4) return 1'b0;
        pos = ND - 1 - slot;
        p10 = 1;
        for (int i = 0; i < pos; i++) p10 = p10 * 10;
        digit = (score / p10) % 10;
        if (pos > 0 && score < p10) return 1'b0;
        return bon && glyph_lit(digit, cy, col);
    endfunction

    function automatic logic [31:0] bcd2(input int v);
        return {24'h0, 4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic step();
        bit r, pt, ng, ft, pt1, pix, nw;
        int ns;
        r   = rst_n;
        pt  = bus.point;
        ng  = bus.new_game;
        ft  = bus.frame_tick;
        pt1 = bus1.point;
        pix = exp_pix(int'(bus.x), int'(bus.y), int'(bus.horizontal_offset), m_score, m_bon);
        @(posedge clk);
        if (!r) begin
            m_score = 0; m_win = 1'b0; m_bc = 0; m_bon = 1'b1;
            m_s1 = 1'b0; m_out = 1'b0;
            m1_score = 0; m1_win = 1'b0;
        end else begin
            m_out = m_s1;
            m_s1  = pix;
            ns = m_score;
            nw = m_win;
            if (ng) begin
                ns = 0; nw = 1'b0; m_bc = 0; m_bon = 1'b1;
            end else begin
                if (pt && !m_win && m_score < 99) ns = m_score + 1;
                if (m_score == WIN) nw = 1'b1;
                if (!m_win) begin
                    m_bc = 0; m_bon = 1'b1;
                end else if (ft) begin
                    if (m_bc == BF - 1) begin
                        m_bc = 0; m_bon = !m_bon;
                    end else begin
                        m_bc = m_bc + 1;
                    end
                end
            end
            m_score = ns;
            m_win   = nw;
            ns = m1_score;
            if (pt1 && !m1_win && m1_score < 9) ns = m1_score + 1;
            if (m1_score == 9) m1_win = 1'b1;
            m1_score = ns;
        end
        #1;
        check_eq("out",       32'(bus.out),        32'(m_out));
        check_eq("win",       32'(bus.win),        32'(m_win));
        check_eq("score",     32'(bus.score_bcd),  bcd2(m_score));
        check_eq("score_nd1", 32'(bus1.score_bcd), 32'(m1_score));
    endtask

    task automatic cyc(input int x, input int y, input bit pt, input bit ng, input bit ft);
        bus.x          = 12'(x);
        bus.y          = 12'(y);
        bus.point      = pt;
        bus.new_game   = ng;
        bus.frame_tick = ft;
        step();
    endtask

    task automatic points(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 1'b1, 1'b0, 1'b0);
            cyc(0, 0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bus.x = '0; bus.y = '0; bus.horizontal_offset = 12'd100;
        bus.point = 1'b0; bus.new_game = 1'b0; bus.frame_tick = 1'b0;
        bus1.x = '0; bus1.y = '0; bus1.horizontal_offset = '0;
        bus1.point = 1'b0; bus1.new_game = 1'b0; bus1.frame_tick = 1'b0;

        rst_n = 1'b0;
        repeat (3) cyc(0, 0, 1'b1, 1'b0, 1'b0);
        check_eq("rst_score", 32'(bus.score_bcd), 32'h00);
        check_eq("rst_win",   32'(bus.win),       32'h0);
        check_eq("rst_out",   32'(bus.out),       32'h0);
        rst_n = 1'b1;
        cyc(0, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 1; i <= 12; i++) begin
            cyc(0, 0, 1'b1, 1'b0, 1'b0);
            if (i == 11) check_eq("score_11", 32'(bus.score_bcd), 32'h11);
            cyc(0, 0, 1'b0, 1'b0, 1'b0);
            if (i == 11) check_eq("win_rise", 32'(bus.win), 32'h1);
        end
        check_eq("point_ignored", 32'(bus.score_bcd), 32'h11);

        cyc(0, 0, 1'b0, 1'b1, 1'b0);
        points(9);
        cyc(0, 0, 1'b1, 1'b0, 1'b0);
        check_eq("bcd_carry", 32'(bus.score_bcd), 32'h10);

        cyc(0, 0, 1'b0, 1'b1, 1'b0);
        points(7);
        for (int y = VSO - 2; y < VSO + 7 * SEG + 2; y++) begin
            for (int x = 96; x < 100 + ND * 8 * SEG + 4; x++) begin
                cyc(x, y, 1'b0, 1'b0, 1'b0);
            end
        end
        cyc(132, VSO, 1'b0, 1'b0, 1'b0);
        cyc(116, VSO, 1'b0, 1'b0, 1'b0);
        check_eq("px_132_lit", 32'(bus.out), 32'h1);
        cyc(100, VSO, 1'b0, 1'b0, 1'b0);
        check_eq("px_116_gap", 32'(bus.out), 32'h0);
        cyc(0, 0, 1'b0, 1'b0, 1'b0);
        check_eq("tens_blank", 32'(bus.out), 32'h0);

        cyc(0, 0, 1'b0, 1'b1, 1'b0);
        points(11);
        repeat (3) cyc(140, VSO, 1'b0, 1'b0, 1'b0);
        check_eq("win_lit", 32'(bus.out), 32'h1);
        repeat (2) cyc(140, VSO, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(140, VSO, 1'b0, 1'b0, 1'b0);
        check_eq("blink_off", 32'(bus.out), 32'h0);
        repeat (2) cyc(140, VSO, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(140, VSO, 1'b0, 1'b0, 1'b0);
        check_eq("blink_back", 32'(bus.out), 32'h1);
        repeat (2) cyc(140, VSO, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        cyc(140, VSO, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        repeat (2) cyc(140, VSO, 1'b0, 1'b0, 1'b0);
        check_eq("rst_blink_on", 32'(bus.out), 32'h1);

        points(5);
        cyc(0, 0, 1'b1, 1'b1, 1'b0);
        check_eq("ng_point_score", 32'(bus.score_bcd), 32'h00);
        check_eq("ng_point_win",   32'(bus.win),       32'h0);

        bus1.point = 1'b1;
        repeat (10) cyc(0, 0, 1'b0, 1'b0, 1'b0);
        bus1.point = 1'b0;
        check_eq("sat_1digit", 32'(bus1.score_bcd), 32'h9);
        cyc(0, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            int off;
            if ($urandom_range(0, 499) == 0) begin
                case ($urandom_range(0, 2))
                    0: bus.horizontal_offset = 12'd100;
                    1: bus.horizontal_offset = 12'd237;
                    default: bus.horizontal_offset = 12'd41;
                endcase
            end
            rst_n = ($urandom_range(0, 1499) != 0);
            off = int'(bus.horizontal_offset);
            cyc(off - 4 + int'($urandom_range(0, ND * 8 * SEG + 8)),
                VSO - 3 + int'($urandom_range(0, 7 * SEG + 6)),
                ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 599) == 0),
                ($urandom_range(0, 9) == 0));
        end
        rst_n = 1'b1;
        cyc(0, 0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
